commit_lockstep_checker: RTL and testbench

Receive-side lockstep checker for the commit channel: it consumes two independent commit streams, DUT and reference model, and buffers each in its own FIFO. It pairs commits in order, compares them field by field, and latches the first divergence. It sits in the testbench top beside the commit interfaces and gives the UVM environment and waveform debug a cycle-accurate, simulator-independent mismatch flag.

---
 rtl/commit_pkg.sv | 72 +++++++
 rtl/commit_fifo.sv | 50 +++++
 rtl/commit_lockstep_checker.sv | 141 ++++++++++++++
 tb/tb_commit_lockstep_checker.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_pkg.sv
// Shared types for the commit lockstep checker: commit packet, FIFO entry, compare mask, state.
// COMMIT_CHK_MEM_CMP_EN adds the memory fields to the stored entry and the compare.
package commit_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        trap;
    logic [1:0]  priv;
  } commit_pkt_t;

  localparam int CMP_PC    = 0;
  localparam int CMP_INSTR = 1;
  localparam int CMP_RD    = 2;
  localparam int CMP_MEM   = 3;
  localparam int CMP_TRAP  = 4;
  localparam int CMP_PRIV  = 5;
  localparam int CMP_W     = 6;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef enum logic {RUN, HALT} chk_state_t;

`ifdef COMMIT_CHK_MEM_CMP_EN
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        trap;
    logic [1:0]  priv;
  } commit_entry_t;
`else
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        trap;
    logic [1:0]  priv;
  } commit_entry_t;
`endif

  // x0 writes carry no architectural data, so rd_data only matters for rd_addr != 0.
  function automatic logic [CMP_W-1:0] compare_entries(input commit_entry_t a,
                                                       input commit_entry_t b);
    logic [CMP_W-1:0] m;
    m = '0;
    m[CMP_PC]    = (a.pc != b.pc);
    m[CMP_INSTR] = (a.instr != b.instr);
    m[CMP_RD]    = (a.rd_addr != b.rd_addr) ||
                   ((a.rd_addr != 5'd0) && (a.rd_data != b.rd_data));
`ifdef COMMIT_CHK_MEM_CMP_EN
    m[CMP_MEM]   = (a.mem_we != b.mem_we) ||
                   (a.mem_we && ((a.mem_addr != b.mem_addr) || (a.mem_wdata != b.mem_wdata)));
`endif
    m[CMP_TRAP]  = (a.trap != b.trap);
    m[CMP_PRIV]  = (a.priv != b.priv);
    return m;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO for one commit stream; a push to a full FIFO is accepted only alongside a pop.
// Entry width follows commit_entry_t, which shrinks when COMMIT_CHK_MEM_CMP_EN is undefined.
module commit_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t rdata
);

  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/commit_lockstep_checker.sv
// Pairs DUT and reference commits in order, compares them and latches the first divergence.
// COMMIT_CHK_MEM_CMP_EN enables the mem_we/mem_addr/mem_wdata compare (mask bit 3).
module commit_lockstep_checker
  import commit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      dut_valid,
  input  logic [$bits(commit_pkt_t)-1:0] dut_pkt,
  input  logic                      ref_valid,
  input  logic [$bits(commit_pkt_t)-1:0] ref_pkt,
  output logic                      mismatch,
  output logic [CMP_W-1:0]          mismatch_mask,
  output logic [CNT_W-1:0]          mismatch_idx,
  output logic                      overflow,
  output logic [CNT_W-1:0]          commit_cnt,
  output logic                      halted
);

  chk_state_t      state;
  commit_pkt_t     dut_p;
  commit_pkt_t     ref_p;
  commit_entry_t   dut_in;
  commit_entry_t   ref_in;
  commit_entry_t   dut_head;
  commit_entry_t   ref_head;
  logic            dut_full, dut_empty, ref_full, ref_empty;
  logic            running;
  logic            pop;
  logic            dut_push, ref_push;
  logic            ovf_event;
  logic [CMP_W-1:0] cmp_mask;

  assign dut_p = dut_pkt;
  assign ref_p = ref_pkt;

  always_comb begin
    dut_in           = '0;
    dut_in.pc        = dut_p.pc;
    dut_in.instr     = dut_p.instr;
    dut_in.rd_addr   = dut_p.rd_addr;
    dut_in.rd_data   = dut_p.rd_data;
    dut_in.trap      = dut_p.trap;
    dut_in.priv      = dut_p.priv;
    ref_in           = '0;
    ref_in.pc        = ref_p.pc;
    ref_in.instr     = ref_p.instr;
    ref_in.rd_addr   = ref_p.rd_addr;
    ref_in.rd_data   = ref_p.rd_data;
    ref_in.trap      = ref_p.trap;
    ref_in.priv      = ref_p.priv;
`ifdef COMMIT_CHK_MEM_CMP_EN
    dut_in.mem_we    = dut_p.mem_we;
    dut_in.mem_addr  = dut_p.mem_addr;
    dut_in.mem_wdata = dut_p.mem_wdata;
    ref_in.mem_we    = ref_p.mem_we;
    ref_in.mem_addr  = ref_p.mem_addr;
    ref_in.mem_wdata = ref_p.mem_wdata;
`endif
  end

`ifndef COMMIT_CHK_MEM_CMP_EN
  logic unused_mem_fields;
  assign unused_mem_fields = ^{dut_p.mem_we, dut_p.mem_addr, dut_p.mem_wdata,
                               ref_p.mem_we, ref_p.mem_addr, ref_p.mem_wdata};
`endif

  // clr overrides everything in its cycle, so it also blocks push and pop.
  assign running   = (state == RUN) && !clr;
  assign pop       = running && !dut_empty && !ref_empty;
  assign dut_push  = running && dut_valid && (!dut_full || pop);
  assign ref_push  = running && ref_valid && (!ref_full || pop);
  assign ovf_event = running && ((dut_valid && dut_full && !pop) ||
                                 (ref_valid && ref_full && !pop));
  assign cmp_mask  = compare_entries(dut_head, ref_head);
  assign halted    = (state == HALT);

  commit_fifo #(.DEPTH(DEPTH), .entry_t(commit_entry_t)) u_dut_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (dut_push),
    .wdata (dut_in),
    .pop   (pop),
    .full  (dut_full),
    .empty (dut_empty),
    .rdata (dut_head)
  );

  commit_fifo #(.DEPTH(DEPTH), .entry_t(commit_entry_t)) u_ref_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (ref_push),
    .wdata (ref_in),
    .pop   (pop),
    .full  (ref_full),
    .empty (ref_empty),
    .rdata (ref_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      mismatch      <= 1'b0;
      mismatch_mask <= '0;
      mismatch_idx  <= '0;
      overflow      <= 1'b0;
      commit_cnt    <= '0;
    end else if (clr) begin
      state         <= RUN;
      mismatch      <= 1'b0;
      mismatch_mask <= '0;
      mismatch_idx  <= '0;
      overflow      <= 1'b0;
      commit_cnt    <= '0;
    end else begin
      if (pop) begin
        if (cmp_mask != '0) begin
          if (!mismatch) begin
            mismatch      <= 1'b1;
            mismatch_mask <= cmp_mask;
            mismatch_idx  <= commit_cnt;
          end
          state <= HALT;
        end else begin
          commit_cnt <= commit_cnt + CNT_W'(1);
        end
      end
      if (ovf_event) begin
        overflow <= 1'b1;
        state    <= HALT;
      end
    end
  end

endmodule

// File: tb/tb_commit_lockstep_checker.sv
// Directed bench for commit_lockstep_checker; mem expectations follow COMMIT_CHK_MEM_CMP_EN.
module tb_commit_lockstep_checker;
  import commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        dut_valid;
  commit_pkt_t dut_pkt;
  logic        ref_valid;
  commit_pkt_t ref_pkt;
  logic        mismatch;
  logic [5:0]  mismatch_mask;
  logic [63:0] mismatch_idx;
  logic        overflow;
  logic [63:0] commit_cnt;
  logic        halted;

  int checks = 0;
  int errors = 0;

  commit_lockstep_checker #(.DEPTH(8), .CNT_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .dut_valid     (dut_valid),
    .dut_pkt       (dut_pkt),
    .ref_valid     (ref_valid),
    .ref_pkt       (ref_pkt),
    .mismatch      (mismatch),
    .mismatch_mask (mismatch_mask),
    .mismatch_idx  (mismatch_idx),
    .overflow      (overflow),
    .commit_cnt    (commit_cnt),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  function automatic commit_pkt_t make_pkt(input int i);
    commit_pkt_t p;
    p           = '0;
    p.pc        = 64'h8000_0000 + 64'(4 * i);
    p.instr     = 32'h0000_0013 + (32'(i) << 8);
    p.rd_addr   = 5'((i % 31) + 1);
    p.rd_data   = 64'(i) * 64'h1111 + 64'd1;
    p.priv      = PRIV_M;
    return p;
  endfunction

  task automatic idle();
    @(negedge clk);
    dut_valid = 1'b0;
    ref_valid = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic push_pair(input commit_pkt_t d, input commit_pkt_t r);
    @(negedge clk);
    dut_valid = 1'b1; dut_pkt = d;
    ref_valid = 1'b1; ref_pkt = r;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1; dut_valid = 1'b0; ref_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic settle();
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; dut_valid = 1'b0; ref_valid = 1'b0;
    dut_pkt = '0; ref_pkt = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({mismatch, mismatch_mask, overflow, halted} !== 9'd0) begin errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0", {mismatch, mismatch_mask, overflow, halted}); end
    checks++; if (commit_cnt !== 64'd0 || mismatch_idx !== 64'd0) begin errors++;
      $display("[TB] FAIL reset_counts: got cnt=%0d idx=%0d expected 0/0", commit_cnt, mismatch_idx); end
  endtask

  task automatic test_latency();
    pulse_clr();
    push_pair(make_pkt(0), make_pkt(0));
    idle();
    checks++; if (commit_cnt !== 64'd0) begin errors++;
      $display("[TB] FAIL latency_early: got %0d expected 0", commit_cnt); end
    @(negedge clk);
    checks++; if (commit_cnt !== 64'd1) begin errors++;
      $display("[TB] FAIL latency_n2: got %0d expected 1", commit_cnt); end
  endtask

  task automatic test_matched();
    pulse_clr();
    for (int i = 0; i < 20; i++) push_pair(make_pkt(i), make_pkt(i));
    settle();
    checks++; if (commit_cnt !== 64'd20) begin errors++;
      $display("[TB] FAIL matched_cnt: got %0d expected 20", commit_cnt); end
    checks++; if (mismatch !== 1'b0 || halted !== 1'b0 || overflow !== 1'b0) begin errors++;
      $display("[TB] FAIL matched_flags: got mm=%b halt=%b ovf=%b expected 0/0/0", mismatch, halted, overflow); end
  endtask

  // lag = cycles REF starts after DUT; lag 7 leaves DUT 8 deep at the first pop.
  task automatic test_skew(input int lag, input bit exp_ovf);
    pulse_clr();
    for (int c = 0; c < lag + 20; c++) begin
      @(negedge clk);
      dut_valid = (c < 20);
      dut_pkt   = make_pkt(c);
      ref_valid = (c >= lag) && (c - lag < 20);
      ref_pkt   = make_pkt(c - lag);
    end
    settle();
    checks++; if (overflow !== exp_ovf || halted !== exp_ovf) begin errors++;
      $display("[TB] FAIL skew%0d_ovf: got ovf=%b halt=%b expected %b", lag, overflow, halted, exp_ovf); end
    checks++; if (commit_cnt !== (exp_ovf ? 64'd0 : 64'd20)) begin errors++;
      $display("[TB] FAIL skew%0d_cnt: got %0d expected %0d", lag, commit_cnt, exp_ovf ? 0 : 20); end
    checks++; if (mismatch !== 1'b0) begin errors++;
      $display("[TB] FAIL skew%0d_mm: got %b expected 0", lag, mismatch); end
  endtask

  task automatic test_rd_data();
    commit_pkt_t d, r;
    pulse_clr();
    for (int i = 0; i < 10; i++) begin
      d = make_pkt(i); r = d;
      if (i == 5) begin
        d.rd_addr = 5'd3; r.rd_addr = 5'd3; d.rd_data = 64'h2; r.rd_data = 64'h1;
      end
      push_pair(d, r);
    end
    settle();
    checks++; if (mismatch !== 1'b1 || halted !== 1'b1) begin errors++;
      $display("[TB] FAIL rd_flags: got mm=%b halt=%b expected 1/1", mismatch, halted); end
    checks++; if (mismatch_mask !== 6'b000100) begin errors++;
      $display("[TB] FAIL rd_mask: got %b expected 000100", mismatch_mask); end
    checks++; if (mismatch_idx !== 64'd5 || commit_cnt !== 64'd5) begin errors++;
      $display("[TB] FAIL rd_idx_cnt: got idx=%0d cnt=%0d expected 5/5", mismatch_idx, commit_cnt); end
    d = make_pkt(40); r = d; r.pc = 64'hdead_0000;
    push_pair(d, r);
    settle();
    checks++; if (mismatch_mask !== 6'b000100 || mismatch_idx !== 64'd5) begin errors++;
      $display("[TB] FAIL first_only: got mask=%b idx=%0d expected 000100/5", mismatch_mask, mismatch_idx); end
  endtask

  task automatic test_halt_ignores();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dut_valid = 1'b1; dut_pkt = make_pkt(i); ref_valid = 1'b0;
    end
    settle();
    checks++; if (overflow !== 1'b0 || commit_cnt !== 64'd5) begin errors++;
      $display("[TB] FAIL halt_ignore: got ovf=%b cnt=%0d expected 0/5", overflow, commit_cnt); end
  endtask

  task automatic test_clr();
    @(negedge clk);
    clr = 1'b1; dut_valid = 1'b1; dut_pkt = make_pkt(7); ref_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0; dut_valid = 1'b0;
    checks++; if ({mismatch, mismatch_mask, overflow, halted} !== 9'd0) begin errors++;
      $display("[TB] FAIL clr_flags: got %b expected 0", {mismatch, mismatch_mask, overflow, halted}); end
    checks++; if (commit_cnt !== 64'd0 || mismatch_idx !== 64'd0) begin errors++;
      $display("[TB] FAIL clr_counts: got cnt=%0d idx=%0d expected 0/0", commit_cnt, mismatch_idx); end
    ref_valid = 1'b1; ref_pkt = make_pkt(7);
    settle();
    checks++; if (commit_cnt !== 64'd0) begin errors++;
      $display("[TB] FAIL clr_push_dropped: got %0d expected 0", commit_cnt); end
    pulse_clr();
    push_pair(make_pkt(1), make_pkt(1));
    settle();
    checks++; if (commit_cnt !== 64'd1 || mismatch !== 1'b0) begin errors++;
      $display("[TB] FAIL clr_fresh: got cnt=%0d mm=%b expected 1/0", commit_cnt, mismatch); end
  endtask

  task automatic test_x0();
    commit_pkt_t d, r;
    pulse_clr();
    d = make_pkt(2); d.rd_addr = 5'd0; r = d;
    d.rd_data = 64'hDEAD; r.rd_data = 64'hBEEF;
    push_pair(d, r);
    settle();
    checks++; if (mismatch !== 1'b0 || commit_cnt !== 64'd1) begin errors++;
      $display("[TB] FAIL x0_write: got mm=%b cnt=%0d expected 0/1", mismatch, commit_cnt); end
  endtask

  task automatic test_mem();
    commit_pkt_t d, r;
    pulse_clr();
    d = make_pkt(3); r = d;
    d.mem_addr = 64'h2000; r.mem_addr = 64'h3000;
    push_pair(d, r);
    d = make_pkt(4); d.mem_we = 1'b1; d.mem_addr = 64'h1000; r = d;
    d.mem_wdata = 64'h11; r.mem_wdata = 64'h22;
    push_pair(d, r);
    settle();
`ifdef COMMIT_CHK_MEM_CMP_EN
    checks++; if (mismatch !== 1'b1 || mismatch_mask !== 6'b001000) begin errors++;
      $display("[TB] FAIL mem_mask: got mm=%b mask=%b expected 1/001000", mismatch, mismatch_mask); end
    checks++; if (mismatch_idx !== 64'd1 || commit_cnt !== 64'd1) begin errors++;
      $display("[TB] FAIL mem_idx: got idx=%0d cnt=%0d expected 1/1", mismatch_idx, commit_cnt); end
`else
    checks++; if (mismatch !== 1'b0 || mismatch_mask !== 6'b000000) begin errors++;
      $display("[TB] FAIL mem_ignored: got mm=%b mask=%b expected 0/000000", mismatch, mismatch_mask); end
    checks++; if (commit_cnt !== 64'd2) begin errors++;
      $display("[TB] FAIL mem_cnt: got %0d expected 2", commit_cnt); end
`endif
  endtask

  task automatic test_fields();
    commit_pkt_t d, r;
    pulse_clr();
    d = make_pkt(9); r = d; r.pc = d.pc + 64'd4;
    push_pair(d, r);
    settle();
    checks++; if (mismatch_mask !== 6'b000001 || mismatch_idx !== 64'd0) begin errors++;
      $display("[TB] FAIL pc_mask: got mask=%b idx=%0d expected 000001/0", mismatch_mask, mismatch_idx); end
    pulse_clr();
    push_pair(make_pkt(0), make_pkt(0));
    d = make_pkt(1); r = d; r.instr = 32'h0000_0073;
    push_pair(d, r);
    settle();
    checks++; if (mismatch_mask !== 6'b000010 || mismatch_idx !== 64'd1) begin errors++;
      $display("[TB] FAIL instr_mask: got mask=%b idx=%0d expected 000010/1", mismatch_mask, mismatch_idx); end
    pulse_clr();
    d = make_pkt(2); r = d; r.trap = 1'b1; r.priv = PRIV_S;
    push_pair(d, r);
    settle();
    checks++; if (mismatch_mask !== 6'b110000) begin errors++;
      $display("[TB] FAIL trap_priv_mask: got %b expected 110000", mismatch_mask); end
    pulse_clr();
    d = make_pkt(3); r = d; r.rd_addr = d.rd_addr + 5'd1;
    push_pair(d, r);
    settle();
    checks++; if (mismatch_mask !== 6'b000100) begin errors++;
      $display("[TB] FAIL rd_addr_mask: got %b expected 000100", mismatch_mask); end
  endtask

  task automatic test_async_reset();
    pulse_clr();
    for (int i = 0; i < 3; i++) push_pair(make_pkt(i), make_pkt(i));
    settle();
    checks++; if (commit_cnt !== 64'd3) begin errors++;
      $display("[TB] FAIL pre_reset_cnt: got %0d expected 3", commit_cnt); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dut_valid = 1'b1; dut_pkt = make_pkt(10 + i); ref_valid = 1'b0;
    end
    idle();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (commit_cnt !== 64'd0 || halted !== 1'b0) begin errors++;
      $display("[TB] FAIL async_reset: got cnt=%0d halt=%b expected 0/0", commit_cnt, halted); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ref_valid = 1'b1; ref_pkt = make_pkt(10 + i); dut_valid = 1'b0;
    end
    settle();
    checks++; if (commit_cnt !== 64'd0 || mismatch !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_flush: got cnt=%0d mm=%b expected 0/0", commit_cnt, mismatch); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_matched();
    test_skew(7, 1'b0);
    test_skew(8, 1'b1);
    test_rd_data();
    test_halt_ignores();
    test_clr();
    test_x0();
    test_mem();
    test_fields();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
